memory_stage: RTL and testbench

- Y86-64 pipeline memory stage. It consumes the M pipeline register written by execute (M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM).
- It performs the data-memory access and produces the forwarding outputs m_valM and m_stat.
- It owns the W pipeline register that feeds writeback and the forwarding/hazard logic.

---
 rtl/y86_pkg.sv | 38 +++
 rtl/data_mem.sv | 57 +++++
 rtl/memory_stage.sv | 112 +++++++++++
 tb/tb_memory_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline constants: status codes, instruction codes, register sentinel.
// Used by the fetch, decode, execute and memory stages.
package y86_pkg;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE    = 4'hF;

    function automatic logic is_mem_read(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_RET) || (icode == I_POPQ);
    endfunction

    function automatic logic is_mem_write(input logic [3:0] icode);
        return (icode == I_RMMOVQ) || (icode == I_CALL) || (icode == I_PUSHQ);
    endfunction

    // Stack-popping instructions address memory through valA (the old %rsp).
    function automatic logic addr_from_vala(input logic [3:0] icode);
        return (icode == I_RET) || (icode == I_POPQ);
    endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-addressed data memory: combinational 8-byte little-endian read, clocked write.
// Define DMEM_ALIGN_CHECK_EN to also fault accesses whose address is not 8-byte aligned.
module data_mem #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic        wr_allow_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] rdata_o,
    output logic        err_o
);

    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0]    mem [MEM_BYTES];
    logic [AW-1:0] base;
    logic          access;
    logic          out_of_range;
    logic          misaligned;
    logic          we;

    assign base         = addr_i[AW-1:0];
    assign access       = rd_i | wr_i;
    assign out_of_range = addr_i > 64'(MEM_BYTES - 8);

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = addr_i[2:0] != 3'd0;
`else
    assign misaligned = 1'b0;
`endif

    assign err_o = access & (out_of_range | misaligned);

    // Only meaningful when err_o is low; the caller masks the data otherwise.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < 8; i++) begin
            rdata_o[8*i +: 8] = mem[base + AW'(i)];
        end
    end

    // Reset is sampled at the edge so a write coinciding with reset is dropped.
    assign we = wr_i & wr_allow_i & ~err_o & ~reset;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                mem[base + AW'(i)] <= wdata_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: data access, m_* forwarding outputs and the W pipeline register.
// DMEM_ALIGN_CHECK_EN (checked in data_mem) enables the alignment fault.
import y86_pkg::*;

module memory_stage #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic        W_stall,
    output logic [63:0] m_valM,
    output logic [1:0]  m_stat,
    output logic [1:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM
);

    logic        mem_read;
    logic        mem_write;
    logic        dmem_error;
    logic        wr_allow;
    logic [63:0] addr;
    logic [63:0] rdata;
    logic        cnd_unused;

    logic [1:0]  w_stat_q,  w_stat_d;
    logic [3:0]  w_icode_q, w_icode_d;
    logic [63:0] w_vale_q,  w_vale_d;
    logic [63:0] w_valm_q,  w_valm_d;
    logic [3:0]  w_dste_q,  w_dste_d;
    logic [3:0]  w_dstm_q,  w_dstm_d;

    // Condition flag only travels with the instruction for tracing.
    assign cnd_unused = M_Cnd;

    assign mem_read  = is_mem_read(M_icode);
    assign mem_write = is_mem_write(M_icode);
    assign addr      = addr_from_vala(M_icode) ? M_valA : M_valE;

    // A write is held off while this or the older instruction is already faulting.
    assign wr_allow = (M_stat == STAT_AOK) && (w_stat_q == STAT_AOK) && !W_stall;

    data_mem #(
        .MEM_BYTES (MEM_BYTES)
    ) u_data_mem (
        .clk        (clk),
        .reset      (reset),
        .rd_i       (mem_read),
        .wr_i       (mem_write),
        .wr_allow_i (wr_allow),
        .addr_i     (addr),
        .wdata_i    (M_valA),
        .rdata_o    (rdata),
        .err_o      (dmem_error)
    );

    assign m_stat = dmem_error ? STAT_ADR : M_stat;
    assign m_valM = (mem_read && !dmem_error) ? rdata : 64'd0;

    always_comb begin
        w_stat_d  = w_stat_q;
        w_icode_d = w_icode_q;
        w_vale_d  = w_vale_q;
        w_valm_d  = w_valm_q;
        w_dste_d  = w_dste_q;
        w_dstm_d  = w_dstm_q;
        if (!W_stall) begin
            w_stat_d  = m_stat;
            w_icode_d = M_icode;
            w_vale_d  = M_valE;
            w_valm_d  = m_valM;
            w_dste_d  = M_dstE;
            w_dstm_d  = M_dstM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_stat_q  <= STAT_AOK;
            w_icode_q <= I_NOP;
            w_vale_q  <= '0;
            w_valm_q  <= '0;
            w_dste_q  <= RNONE;
            w_dstm_q  <= RNONE;
        end else begin
            w_stat_q  <= w_stat_d;
            w_icode_q <= w_icode_d;
            w_vale_q  <= w_vale_d;
            w_valm_q  <= w_valm_d;
            w_dste_q  <= w_dste_d;
            w_dstm_q  <= w_dstm_d;
        end
    end

    assign W_stat  = w_stat_q;
    assign W_icode = w_icode_q;
    assign W_valE  = w_vale_q;
    assign W_valM  = w_valm_q;
    assign W_dstE  = w_dste_q;
    assign W_dstM  = w_dstm_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus random traffic vs. a byte-array model.
module tb_memory_stage;

    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE, M_valA;
    logic [3:0]  M_dstE, M_dstM;
    logic        W_stall;
    logic [63:0] m_valM;
    logic [1:0]  m_stat;
    logic [1:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  W_dstE, W_dstM;

    memory_stage #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .reset(reset),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_stall(W_stall),
        .m_valM(m_valM), .m_stat(m_stat),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference state
    logic [7:0]  mem_m [MEM_BYTES];
    logic [1:0]  mw_stat;
    logic [3:0]  mw_icode, mw_dste, mw_dstm;
    logic [63:0] mw_vale, mw_valm;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mw_stat = 2'd0; mw_icode = 4'd1; mw_vale = 64'd0;
        mw_valm = 64'd0; mw_dste = 4'hF; mw_dstm = 4'hF;
    endtask

    function automatic logic [63:0] model_read(input longint unsigned a);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = mem_m[int'(a) + i];
        return r;
    endfunction

    task automatic check_w(input string pfx);
        check({pfx, "_W_stat"},  64'(W_stat),  64'(mw_stat));
        check({pfx, "_W_icode"}, 64'(W_icode), 64'(mw_icode));
        check({pfx, "_W_valE"},  W_valE,       mw_vale);
        check({pfx, "_W_valM"},  W_valM,       mw_valm);
        check({pfx, "_W_dstE"},  64'(W_dstE),  64'(mw_dste));
        check({pfx, "_W_dstM"},  64'(W_dstM),  64'(mw_dstm));
    endtask

    // One pipeline cycle: drive at negedge, check m_* before the edge, W_* after it.
    task automatic step(input logic [1:0] st, input logic [3:0] ic,
                        input logic [63:0] ve, input logic [63:0] va,
                        input logic [3:0] de, input logic [3:0] dm, input logic stall);
        bit rd, wr, err, commit;
        longint unsigned a;
        logic [1:0]  e_stat;
        logic [63:0] e_valm;
        @(negedge clk);
        M_stat = st; M_icode = ic; M_Cnd = 1'($urandom_range(0, 1));
        M_valE = ve; M_valA = va; M_dstE = de; M_dstM = dm; W_stall = stall;
        #1;
        rd  = (ic == 5) || (ic == 9) || (ic == 11);
        wr  = (ic == 4) || (ic == 8) || (ic == 10);
        a   = ((ic == 9) || (ic == 11)) ? va : ve;
        err = (rd || wr) && (a > longint'(MEM_BYTES - 8));
`ifdef DMEM_ALIGN_CHECK_EN
        if ((rd || wr) && (a % 8 != 0)) err = 1;
`endif
        e_stat = err ? 2'd2 : st;
        e_valm = (rd && !err) ? model_read(a) : 64'd0;
        check("m_stat", 64'(m_stat), 64'(e_stat));
        check("m_valM", m_valM, e_valm);
        commit = wr && !err && (st == 0) && (mw_stat == 0) && !stall;
        @(posedge clk);
        if (commit)
            for (int i = 0; i < 8; i++) mem_m[int'(a) + i] = va[8*i +: 8];
        if (!stall) begin
            mw_stat = e_stat; mw_icode = ic; mw_vale = ve;
            mw_valm = e_valm; mw_dste = de; mw_dstm = dm;
        end
        #1;
        check_w("step");
    endtask

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 9))
            6:       return 64'($urandom_range(MEM_BYTES - 14, MEM_BYTES + 6));
            7:       return {$urandom, $urandom};
            8:       return 64'hFFFF_FFFF_FFFF_FFF8;
            9:       return 64'($urandom_range(0, MEM_BYTES / 8 - 1) * 8);
            default: return 64'($urandom_range(0, MEM_BYTES - 8));
        endcase
    endfunction

    initial begin
        logic [63:0] ad, dat;
        logic [3:0]  ic;
        reset = 1'b1;
        M_stat = 0; M_icode = 4'd1; M_Cnd = 0; M_valE = 0; M_valA = 0;
        M_dstE = 4'hF; M_dstM = 4'hF; W_stall = 0;
        model_reset();
        #1;
        check_w("reset0");
        @(posedge clk);
        #1 reset = 1'b0;

        // Initialise every byte with known data through aligned stores.
        for (int a = 0; a < MEM_BYTES; a += 8)
            step(0, 4, 64'(a), {$urandom, $urandom}, 4'hF, 4'hF, 0);

        // Store then load
        step(0, 4, 64'd16, 64'h1122334455667788, 4'hF, 4'hF, 0);
        step(0, 5, 64'd16, 64'd0, 4'hF, 4'd9, 0);
        check("ld_W_valM", W_valM, 64'h1122334455667788);
        check("ld_W_dstM", 64'(W_dstM), 64'd9);
        step(0, 5, 64'd17, 64'd0, 4'hF, 4'd2, 0);

        // Call / ret at the top boundary
        step(0, 8, 64'd1016, 64'h40, 4'd4, 4'hF, 0);
        step(0, 9, 64'd1024, 64'd1016, 4'd4, 4'hF, 0);
        check("ret_W_valM", W_valM, 64'h40);
        check("ret_W_stat", 64'(W_stat), 64'd0);

        // Bounds faults
        step(0, 5, 64'd1020, 64'd0, 4'hF, 4'd1, 0);
        check("oob_rd_W_stat", 64'(W_stat), 64'd2);
        step(0, 0, 64'd0, 64'd0, 4'hF, 4'hF, 0);
        step(0, 4, 64'd1020, 64'hAAAA_BBBB_CCCC_DDDD, 4'hF, 4'hF, 0);
        step(0, 5, 64'd1016, 64'd0, 4'hF, 4'd1, 0);
        check("oob_wr_unchanged", W_valM, 64'h40);
        step(0, 11, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 4'd4, 4'd3, 0);

        // Alignment
        step(0, 4, 64'd12, 64'h0102030405060708, 4'hF, 4'hF, 0);
        step(0, 5, 64'd12, 64'd0, 4'hF, 4'd5, 0);
        step(0, 5, 64'd8, 64'd0, 4'hF, 4'd5, 0);
        step(0, 5, 64'd16, 64'd0, 4'hF, 4'd5, 0);

        // Stall and suppression
        step(0, 6, 64'd7, 64'd0, 4'd2, 4'hF, 0);
        step(0, 6, 64'd99, 64'd0, 4'd3, 4'hF, 1);
        check("stall_W_valE", W_valE, 64'd7);
        step(0, 6, 64'd99, 64'd0, 4'd3, 4'hF, 0);
        check("rel_W_valE", W_valE, 64'd99);
        check("rel_W_dstE", 64'(W_dstE), 64'd3);
        check("rel_W_valM", W_valM, 64'd0);
        step(1, 0, 64'd0, 64'd0, 4'hF, 4'hF, 0);
        step(0, 4, 64'd32, 64'h5555_6666_7777_8888, 4'hF, 4'hF, 0);
        step(0, 4, 64'd40, 64'h1234, 4'hF, 4'hF, 1);
        step(0, 5, 64'd32, 64'd0, 4'hF, 4'd6, 0);
        step(0, 5, 64'd40, 64'd0, 4'hF, 4'd6, 0);

        // Async reset mid-stream with a store pending
        step(0, 6, 64'd99, 64'd0, 4'd3, 4'hF, 0);
        @(negedge clk);
        M_stat = 0; M_icode = 4'd4; M_valE = 64'd24; M_valA = 64'hDEAD_BEEF_0000_0001;
        W_stall = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("rst_W_icode", 64'(W_icode), 64'd1);
        check("rst_W_dstE",  64'(W_dstE),  64'hF);
        check("rst_W_dstM",  64'(W_dstM),  64'hF);
        check("rst_W_valE",  W_valE,       64'd0);
        check("rst_W_stat",  64'(W_stat),  64'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_w("rst_hold");
        M_icode = 4'd1; W_stall = 1'b0;
        reset = 1'b0;
        step(0, 5, 64'd24, 64'd0, 4'hF, 4'd7, 0);

        // Random traffic
        for (int n = 0; n < 2500; n++) begin
            ic  = 4'($urandom_range(0, 11));
            ad  = rand_addr();
            dat = {$urandom, $urandom};
            if (ic == 9 || ic == 11)
                step(($urandom_range(0, 7) < 6) ? 2'd0 : 2'($urandom_range(1, 3)), ic,
                     dat, ad, 4'($urandom), 4'($urandom), $urandom_range(0, 9) == 0);
            else
                step(($urandom_range(0, 7) < 6) ? 2'd0 : 2'($urandom_range(1, 3)), ic,
                     ad, dat, 4'($urandom), 4'($urandom), $urandom_range(0, 9) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
